// File: rtl/axi4_slave_wbm_bridge_if.sv
// Bus bundle for the AXI4-to-Wishbone bridge: the AXI4 responder channels
// plus the classic Wishbone master signals. The "slave" modport is the
// bridge's own view (AXI responder, Wishbone initiator); the "master"
// modport is the view of the environment around it.
interface axi4_slave_wbm_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int ID_W   = 1,
    parameter int WB_AW  = 30
);
    logic              s_axi_awvalid;
    logic [ID_W-1:0]   s_axi_awid;
    logic [ADDR_W-1:0] s_axi_awaddr;
    logic [7:0]        s_axi_awlen;
    logic [1:0]        s_axi_awburst;
    logic              s_axi_awready;
    logic              s_axi_wvalid;
    logic [31:0]       s_axi_wdata;
    logic [3:0]        s_axi_wstrb;
    logic              s_axi_wlast;
    logic              s_axi_wready;
    logic              s_axi_bvalid;
    logic [ID_W-1:0]   s_axi_bid;
    logic [1:0]        s_axi_bresp;
    logic              s_axi_bready;
    logic              s_axi_arvalid;
    logic [ID_W-1:0]   s_axi_arid;
    logic [ADDR_W-1:0] s_axi_araddr;
    logic [7:0]        s_axi_arlen;
    logic [1:0]        s_axi_arburst;
    logic              s_axi_arready;
    logic              s_axi_rvalid;
    logic [ID_W-1:0]   s_axi_rid;
    logic [31:0]       s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rlast;
    logic              s_axi_rready;
    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic              wb_we_o;
    logic [WB_AW-1:0]  wb_adr_o;
    logic [31:0]       wb_dat_o;
    logic [3:0]        wb_sel_o;
    logic [31:0]       wb_dat_i;
    logic              wb_ack_i;
    logic              wb_err_i;

    modport slave (
        input  s_axi_awvalid, s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awburst,
        output s_axi_awready,
        input  s_axi_wvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast,
        output s_axi_wready,
        output s_axi_bvalid, s_axi_bid, s_axi_bresp,
        input  s_axi_bready,
        input  s_axi_arvalid, s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arburst,
        output s_axi_arready,
        output s_axi_rvalid, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
        input  s_axi_rready,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport master (
        output s_axi_awvalid, s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awburst,
        input  s_axi_awready,
        output s_axi_wvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast,
        input  s_axi_wready,
        input  s_axi_bvalid, s_axi_bid, s_axi_bresp,
        output s_axi_bready,
        output s_axi_arvalid, s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arburst,
        input  s_axi_arready,
        input  s_axi_rvalid, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
        output s_axi_rready,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );
endinterface

// File: rtl/axi4_slave_wbm_bridge.sv
// AXI4 responder that replays each accepted burst beat-by-beat as classic
// Wishbone cycles. One transaction in flight; INCR and FIXED bursts (WRAP
// behaves as INCR). A stuck Wishbone slave is cut off after TIMEOUT cycles.
module axi4_slave_wbm_bridge #(
    parameter int ADDR_W  = 32,
    parameter int ID_W    = 1,
    parameter int WB_AW   = 30,
    parameter int TIMEOUT = 255
) (
    input logic                     clock,
    input logic                     reset_n,
    axi4_slave_wbm_bridge_if.slave  bus
);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, WDAT, WBUS, BRESP, RBUS, RDAT} state_t;

    state_t           state_reg, state_next;
    logic [ID_W-1:0]  id_reg;
    logic [WB_AW-1:0] adr_reg;
    logic [7:0]       len_reg;
    logic [7:0]       beat_reg;
    logic             fixed_reg;
    logic             err_reg;
    logic [31:0]      dat_reg;
    logic [3:0]       sel_reg;
    logic [31:0]      rdata_reg;
    logic [1:0]       rresp_reg;
    logic             aw_pri_reg;   // 0: read wins a tie, 1: write wins
    logic [TW-1:0]    tmo_reg;

    logic grant_ar, grant_aw, tmo_hit, bus_fail, bus_done, is_last;
    logic unused_addr_bits;

    assign unused_addr_bits = ^{bus.s_axi_awaddr[1:0], bus.s_axi_araddr[1:0]};

    assign grant_ar = bus.s_axi_arvalid & (~bus.s_axi_awvalid | ~aw_pri_reg);
    assign grant_aw = bus.s_axi_awvalid & ~grant_ar;
    assign is_last  = (beat_reg == len_reg);

    generate
        if (TIMEOUT == 0) begin : g_no_tmo
            assign tmo_hit = 1'b0;
        end else begin : g_tmo
            assign tmo_hit = (tmo_reg == TW'(TIMEOUT - 1));
        end
    endgenerate

    // Error (or timeout) takes precedence over a simultaneous ack.
    assign bus_fail = bus.wb_err_i | tmo_hit;
    assign bus_done = bus.wb_ack_i | bus_fail;

    // State register; reset abandons any burst without a response.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    // Next-state decode.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_ar) state_next = RBUS;
                     else if (grant_aw) state_next = WDAT;
            WDAT:    if (bus.s_axi_wvalid) state_next = WBUS;
            WBUS:    if (bus_done) state_next = is_last ? BRESP : WDAT;
            BRESP:   if (bus.s_axi_bready) state_next = IDLE;
            RBUS:    if (bus_done) state_next = RDAT;
            RDAT:    if (bus.s_axi_rready) state_next = is_last ? IDLE : RBUS;
            default: state_next = IDLE;
        endcase
    end

    // Bus outputs decoded from state and the latched transaction fields.
    always_comb begin
        bus.s_axi_awready = (state_reg == IDLE) & grant_aw;
        bus.s_axi_arready = (state_reg == IDLE) & grant_ar;
        bus.s_axi_wready  = (state_reg == WDAT);
        bus.s_axi_bvalid  = (state_reg == BRESP);
        bus.s_axi_bid     = id_reg;
        bus.s_axi_bresp   = {err_reg, 1'b0};
        bus.s_axi_rvalid  = (state_reg == RDAT);
        bus.s_axi_rid     = id_reg;
        bus.s_axi_rdata   = rdata_reg;
        bus.s_axi_rresp   = rresp_reg;
        bus.s_axi_rlast   = (state_reg == RDAT) & is_last;
        bus.wb_cyc_o      = (state_reg == WBUS) | (state_reg == RBUS);
        bus.wb_stb_o      = (state_reg == WBUS) | (state_reg == RBUS);
        bus.wb_we_o       = (state_reg == WBUS);
        bus.wb_adr_o      = adr_reg;
        bus.wb_dat_o      = dat_reg;
        bus.wb_sel_o      = (state_reg == RBUS) ? 4'hF : sel_reg;
    end

    // Transaction datapath: address/beat tracking, write data, read capture.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            id_reg     <= '0;
            adr_reg    <= '0;
            len_reg    <= '0;
            beat_reg   <= '0;
            fixed_reg  <= 1'b0;
            err_reg    <= 1'b0;
            dat_reg    <= '0;
            sel_reg    <= '0;
            rdata_reg  <= '0;
            rresp_reg  <= '0;
            aw_pri_reg <= 1'b0;
            tmo_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    tmo_reg <= '0;
                    if (grant_ar) begin
                        id_reg     <= bus.s_axi_arid;
                        adr_reg    <= bus.s_axi_araddr[WB_AW+1:2];
                        len_reg    <= bus.s_axi_arlen;
                        fixed_reg  <= (bus.s_axi_arburst == 2'b00);
                        beat_reg   <= '0;
                        err_reg    <= 1'b0;
                        aw_pri_reg <= ~aw_pri_reg;
                    end else if (grant_aw) begin
                        id_reg     <= bus.s_axi_awid;
                        adr_reg    <= bus.s_axi_awaddr[WB_AW+1:2];
                        len_reg    <= bus.s_axi_awlen;
                        fixed_reg  <= (bus.s_axi_awburst == 2'b00);
                        beat_reg   <= '0;
                        err_reg    <= 1'b0;
                        aw_pri_reg <= ~aw_pri_reg;
                    end
                end
                WDAT: begin
                    tmo_reg <= '0;
                    if (bus.s_axi_wvalid) begin
                        dat_reg <= bus.s_axi_wdata;
                        sel_reg <= bus.s_axi_wstrb;
                        if (bus.s_axi_wlast != is_last) err_reg <= 1'b1;
                    end
                end
                WBUS: begin
                    if (bus_done) begin
                        if (bus_fail) err_reg <= 1'b1;
                        if (!is_last) begin
                            beat_reg <= beat_reg + 8'd1;
                            if (!fixed_reg) adr_reg <= adr_reg + WB_AW'(1);
                        end
                    end else begin
                        tmo_reg <= tmo_reg + TW'(1);
                    end
                end
                RBUS: begin
                    if (bus_fail) begin
                        rdata_reg <= '0;
                        rresp_reg <= 2'b10;
                    end else if (bus.wb_ack_i) begin
                        rdata_reg <= bus.wb_dat_i;
                        rresp_reg <= 2'b00;
                    end else begin
                        tmo_reg <= tmo_reg + TW'(1);
                    end
                end
                RDAT: begin
                    tmo_reg <= '0;
                    if (bus.s_axi_rready && !is_last) begin
                        beat_reg <= beat_reg + 8'd1;
                        if (!fixed_reg) adr_reg <= adr_reg + WB_AW'(1);
                    end
                end
                default: tmo_reg <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_slave_wbm_bridge.sv
// Directed bench for the AXI4-to-Wishbone bridge with a small Wishbone
// slave model (programmable wait states, error injection, no-ack mode).
module tb_axi4_slave_wbm_bridge;
    localparam int ADDR_W  = 32;
    localparam int ID_W    = 1;
    localparam int WB_AW   = 30;
    localparam int TIMEOUT = 8;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clock = ~clock;

    axi4_slave_wbm_bridge_if #(.ADDR_W(ADDR_W), .ID_W(ID_W), .WB_AW(WB_AW)) bus ();

    axi4_slave_wbm_bridge #(
        .ADDR_W(ADDR_W), .ID_W(ID_W), .WB_AW(WB_AW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Wishbone slave model
    int          wb_wait = 0;
    logic        ack_en = 1'b1;
    logic        err_en = 1'b0;
    logic [29:0] err_adr = '0;
    int          wcnt = 0;
    logic [31:0] mem [4];

    assign bus.wb_ack_i = bus.wb_cyc_o & ack_en & (wcnt == wb_wait);
    assign bus.wb_err_i = bus.wb_cyc_o & err_en & (bus.wb_adr_o == err_adr) & (wcnt == wb_wait);
    assign bus.wb_dat_i = mem[bus.wb_adr_o[1:0]];

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) wcnt <= 0;
        else if (!bus.wb_cyc_o || bus.wb_ack_i || bus.wb_err_i) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    // Wishbone cycle log: fields at cycle start, length, stability
    logic [29:0] log_adr [64];
    logic [31:0] log_dat [64];
    logic [3:0]  log_sel [64];
    logic        log_we  [64];
    int          log_len [64];
    int          log_n = 0;
    int          cyc_len = 0;
    int          unstable = 0;
    logic        cyc_prev = 1'b0;

    always @(posedge clock) begin
        if (bus.wb_cyc_o) begin
            if (!cyc_prev) begin
                log_adr[log_n] = bus.wb_adr_o;
                log_dat[log_n] = bus.wb_dat_o;
                log_sel[log_n] = bus.wb_sel_o;
                log_we[log_n]  = bus.wb_we_o;
                cyc_len = 1;
            end else begin
                cyc_len++;
                if (bus.wb_adr_o !== log_adr[log_n] || bus.wb_sel_o !== log_sel[log_n] ||
                    bus.wb_we_o !== log_we[log_n] || (bus.wb_we_o && bus.wb_dat_o !== log_dat[log_n]))
                    unstable++;
            end
        end else if (cyc_prev) begin
            log_len[log_n] = cyc_len;
            if (log_n < 63) log_n++;
        end
        cyc_prev = bus.wb_cyc_o;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=hang required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic axi_aw(input logic [ID_W-1:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [1:0] burst);
        int n = 0;
        bus.s_axi_awvalid = 1'b1;
        bus.s_axi_awid    = id;
        bus.s_axi_awaddr  = a;
        bus.s_axi_awlen   = len;
        bus.s_axi_awburst = burst;
        #1;
        while (!bus.s_axi_awready && n < 100) begin tick(); n++; end
        check("aw_ready", bus.s_axi_awready, 1);
        tick();
        bus.s_axi_awvalid = 1'b0;
    endtask

    task automatic axi_ar(input logic [ID_W-1:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [1:0] burst);
        int n = 0;
        bus.s_axi_arvalid = 1'b1;
        bus.s_axi_arid    = id;
        bus.s_axi_araddr  = a;
        bus.s_axi_arlen   = len;
        bus.s_axi_arburst = burst;
        #1;
        while (!bus.s_axi_arready && n < 100) begin tick(); n++; end
        check("ar_ready", bus.s_axi_arready, 1);
        tick();
        bus.s_axi_arvalid = 1'b0;
    endtask

    task automatic axi_w(input logic [31:0] d, input logic [3:0] s, input logic l);
        int n = 0;
        bus.s_axi_wvalid = 1'b1;
        bus.s_axi_wdata  = d;
        bus.s_axi_wstrb  = s;
        bus.s_axi_wlast  = l;
        #1;
        while (!bus.s_axi_wready && n < 100) begin tick(); n++; end
        check("w_ready", bus.s_axi_wready, 1);
        tick();
        bus.s_axi_wvalid = 1'b0;
    endtask

    task automatic axi_b(output logic [ID_W-1:0] id, output logic [1:0] resp);
        int n = 0;
        bus.s_axi_bready = 1'b1;
        while (!bus.s_axi_bvalid && n < 100) begin tick(); n++; end
        check("b_valid", bus.s_axi_bvalid, 1);
        id   = bus.s_axi_bid;
        resp = bus.s_axi_bresp;
        tick();
        bus.s_axi_bready = 1'b0;
    endtask

    task automatic axi_r(input int stall, output logic [31:0] d, output logic [1:0] rs,
                         output logic l);
        int n = 0;
        bus.s_axi_rready = 1'b0;
        while (!bus.s_axi_rvalid && n < 100) begin tick(); n++; end
        check("r_valid", bus.s_axi_rvalid, 1);
        d  = bus.s_axi_rdata;
        rs = bus.s_axi_rresp;
        l  = bus.s_axi_rlast;
        if (stall > 0) begin
            repeat (stall) tick();
            check("r_stable", {bus.s_axi_rvalid, bus.s_axi_rdata, bus.s_axi_rresp, bus.s_axi_rlast},
                  {1'b1, d, rs, l});
        end
        bus.s_axi_rready = 1'b1;
        tick();
        bus.s_axi_rready = 1'b0;
    endtask

    logic [ID_W-1:0] bid;
    logic [1:0]      resp;
    logic [31:0]     rd;
    logic            rl;
    int              base;
    logic [31:0]     exp_rd [4];
    logic [3:0]      fx_strb [3];

    initial begin
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
        exp_rd[0] = 32'h11; exp_rd[1] = 32'h22; exp_rd[2] = 32'h33; exp_rd[3] = 32'h44;
        fx_strb[0] = 4'h3; fx_strb[1] = 4'hC; fx_strb[2] = 4'hF;
        bus.s_axi_awvalid = 0; bus.s_axi_awid = 0; bus.s_axi_awaddr = 0;
        bus.s_axi_awlen = 0; bus.s_axi_awburst = 0;
        bus.s_axi_wvalid = 0; bus.s_axi_wdata = 0; bus.s_axi_wstrb = 0; bus.s_axi_wlast = 0;
        bus.s_axi_bready = 0;
        bus.s_axi_arvalid = 0; bus.s_axi_arid = 0; bus.s_axi_araddr = 0;
        bus.s_axi_arlen = 0; bus.s_axi_arburst = 0;
        bus.s_axi_rready = 0;

        // Step 1: reset state
        repeat (3) tick();
        check("rst_awready", bus.s_axi_awready, 0);
        check("rst_arready", bus.s_axi_arready, 0);
        check("rst_wready", bus.s_axi_wready, 0);
        check("rst_bvalid", bus.s_axi_bvalid, 0);
        check("rst_rvalid", bus.s_axi_rvalid, 0);
        check("rst_cyc_stb_we", {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o}, 0);
        check("rst_resp", {bus.s_axi_bresp, bus.s_axi_rresp}, 0);
        check("rst_rdata", bus.s_axi_rdata, 0);
        check("rst_wb_fields", {bus.wb_adr_o, bus.wb_dat_o, bus.wb_sel_o}, 0);
        reset_n = 1'b1;
        tick();

        // Step 2: zero-wait single write, bvalid 3 cycles after AW handshake
        wb_wait = 0;
        axi_aw(1'b0, 32'h8, 8'd0, 2'b01);
        axi_w(32'h12345678, 4'hF, 1'b1);
        check("wr_lat_bvalid_early", bus.s_axi_bvalid, 0);
        tick();
        check("wr_lat_bvalid", bus.s_axi_bvalid, 1);
        axi_b(bid, resp);
        check("wr_lat_bresp", resp, 2'b00);
        check("wr_lat_adr", log_adr[log_n-1], 30'h2);

        // Step 3: single write with 2 wait states
        wb_wait = 2;
        base = log_n;
        axi_aw(1'b1, 32'h30004, 8'd0, 2'b01);
        axi_w(32'hDEADBEEF, 4'hF, 1'b1);
        axi_b(bid, resp);
        check("sw_bresp", resp, 2'b00);
        check("sw_bid", bid, 1'b1);
        check("sw_ncyc", log_n - base, 1);
        check("sw_adr", log_adr[base], 30'hC001);
        check("sw_dat", log_dat[base], 32'hDEADBEEF);
        check("sw_sel_we", {log_sel[base], log_we[base]}, {4'hF, 1'b1});
        check("sw_cyc_len", log_len[base], 3);

        // Step 4: INCR read burst, zero-wait, 3-cycle rready stalls
        wb_wait = 0;
        base = log_n;
        axi_ar(1'b0, 32'h100, 8'd3, 2'b01);
        check("rd_lat_rvalid_early", bus.s_axi_rvalid, 0);
        tick();
        check("rd_lat_rvalid", bus.s_axi_rvalid, 1);
        for (int i = 0; i < 4; i++) begin
            axi_r(3, rd, resp, rl);
            check($sformatf("incr_rdata%0d", i), rd, exp_rd[i]);
            check($sformatf("incr_rresp%0d", i), resp, 2'b00);
            check($sformatf("incr_rlast%0d", i), rl, (i == 3) ? 1'b1 : 1'b0);
        end
        check("incr_ncyc", log_n - base, 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("incr_adr%0d", i), {log_adr[base+i], log_we[base+i], log_sel[base+i]},
                  {30'h40 + 30'(i), 1'b0, 4'hF});

        // Step 5: FIXED write burst, len 2
        wb_wait = 1;
        base = log_n;
        axi_aw(1'b0, 32'h200, 8'd2, 2'b00);
        for (int i = 0; i < 3; i++)
            axi_w(32'hA0 + 32'(i), fx_strb[i], (i == 2) ? 1'b1 : 1'b0);
        axi_b(bid, resp);
        check("fix_bresp", resp, 2'b00);
        check("fix_ncyc", log_n - base, 3);
        for (int i = 0; i < 3; i++)
            check($sformatf("fix_cyc%0d", i), {log_adr[base+i], log_sel[base+i], log_dat[base+i]},
                  {30'h80, fx_strb[i], 32'hA0 + 32'(i)});

        // Step 6: read with wb_err (and ack) on beat 1 of 3
        wb_wait = 0;
        err_en = 1'b1;
        err_adr = 30'h42;
        axi_ar(1'b1, 32'h104, 8'd2, 2'b01);
        axi_r(0, rd, resp, rl);
        check("err_b0", {rd, resp, rl}, {32'h22, 2'b00, 1'b0});
        axi_r(0, rd, resp, rl);
        check("err_b1", {rd, resp, rl}, {32'h0, 2'b10, 1'b0});
        axi_r(0, rd, resp, rl);
        check("err_b2", {rd, resp, rl}, {32'h44, 2'b00, 1'b1});
        err_en = 1'b0;

        // Step 7: write timeout, slave never acks
        ack_en = 1'b0;
        base = log_n;
        axi_aw(1'b0, 32'h0, 8'd0, 2'b01);
        axi_w(32'h55, 4'hF, 1'b1);
        axi_b(bid, resp);
        check("tmo_bresp", resp, 2'b10);
        check("tmo_cyc_len", log_len[base], TIMEOUT);
        ack_en = 1'b1;

        // Step 8: wlast protocol errors on a 2-beat write
        base = log_n;
        axi_aw(1'b0, 32'h20, 8'd1, 2'b01);
        axi_w(32'h1, 4'hF, 1'b1);
        axi_w(32'h2, 4'hF, 1'b1);
        axi_b(bid, resp);
        check("wlast_bresp", resp, 2'b10);
        check("wlast_ncyc", log_n - base, 2);

        // Step 9: reset during WBUS of beat 2 of a 4-beat write
        wb_wait = 3;
        axi_aw(1'b1, 32'h1000, 8'd3, 2'b01);
        axi_w(32'hB0, 4'hF, 1'b0);
        axi_w(32'hB1, 4'hF, 1'b0);
        axi_w(32'hB2, 4'hF, 1'b0);
        check("mid_cyc_before", bus.wb_cyc_o, 1);
        reset_n = 1'b0;
        #1;
        check("mid_cyc_stb_we", {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o}, 0);
        check("mid_ready_valid", {bus.s_axi_awready, bus.s_axi_arready, bus.s_axi_wready,
                                  bus.s_axi_bvalid, bus.s_axi_rvalid}, 0);
        check("mid_wb_fields", {bus.wb_adr_o, bus.wb_dat_o, bus.wb_sel_o}, 0);
        wb_wait = 0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        check("mid_no_bresp", bus.s_axi_bvalid, 0);

        // Step 10: arbitration after reset: read first, then write, alternating
        base = log_n;
        bus.s_axi_awvalid = 1'b1; bus.s_axi_awid = 1'b1; bus.s_axi_awaddr = 32'h10;
        bus.s_axi_awlen = 8'd0; bus.s_axi_awburst = 2'b01;
        bus.s_axi_arvalid = 1'b1; bus.s_axi_arid = 1'b0; bus.s_axi_araddr = 32'h108;
        bus.s_axi_arlen = 8'd0; bus.s_axi_arburst = 2'b01;
        #1;
        check("arb1_grant", {bus.s_axi_arready, bus.s_axi_awready}, 2'b10);
        tick();
        bus.s_axi_arvalid = 1'b0;
        axi_r(0, rd, resp, rl);
        check("arb1_rdata", rd, 32'h33);
        bus.s_axi_arvalid = 1'b1; bus.s_axi_araddr = 32'h10C;
        #1;
        check("arb2_grant", {bus.s_axi_arready, bus.s_axi_awready}, 2'b01);
        tick();
        bus.s_axi_awvalid = 1'b0;
        axi_w(32'hCAFEF00D, 4'hF, 1'b1);
        axi_b(bid, resp);
        check("arb2_b", {bid, resp}, {1'b1, 2'b00});
        axi_ar(1'b0, 32'h10C, 8'd0, 2'b01);
        axi_r(0, rd, resp, rl);
        check("arb3_rdata", rd, 32'h44);
        check("arb_order", {log_we[base], log_adr[base], log_we[base+1], log_adr[base+1],
                            log_we[base+2]}, {1'b0, 30'h42, 1'b1, 30'h4, 1'b0});
        check("wb_stable", unstable, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
